// File: rtl/mfcc_pkg.sv
// Shared constants and types for the MFCC cepstrum and delta front end.
package mfcc_pkg;

    localparam int CEP_W    = 16;
    localparam int NUM_COEF = 13;
    localparam int NFR      = 5;
    localparam int FR_W     = 3;

    typedef enum logic [2:0] {
        S_NEW,
        S_SUB2,
        S_ADD2,
        S_SUB2B,
        S_ADD1,
        S_SUB1
    } step_t;

    typedef enum logic {
        ACCEPT,
        CALC
    } state_t;

    // Ring-pointer addition modulo NFR; both operands must already be < NFR.
    function automatic logic [FR_W-1:0] fr_add(input logic [FR_W-1:0] f,
                                               input logic [FR_W-1:0] d);
        logic [FR_W:0] s;
        s = {1'b0, f} + {1'b0, d};
        if (s >= (FR_W+1)'(NFR))
            s = s - (FR_W+1)'(NFR);
        return s[FR_W-1:0];
    endfunction

endpackage

// File: rtl/cep_hist_buf.sv
// Five-frame ring of cepstral coefficients: one write port, one combinational
// read port addressed by frame slot and coefficient index.
module cep_hist_buf
    import mfcc_pkg::*;
#(
    parameter int NUM_COEF = mfcc_pkg::NUM_COEF,
    parameter int IDX_W    = 4
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [FR_W-1:0]        wr_frame,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [CEP_W-1:0]       wr_data,
    input  logic [FR_W-1:0]        rd_frame,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [CEP_W-1:0]       rd_data
);

    // Pure storage; contents are only read after a full history has been written.
    logic [CEP_W-1:0] mem [NFR][NUM_COEF];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_frame][wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_frame][rd_idx];

endmodule

// File: rtl/delta_seq.sv
// Buffers five cepstral frames and drives the delta accumulator with the
// six-step sequence 2*(c[t+2]-c[t-2]) + (c[t+1]-c[t-1]) per coefficient.
//
// state  | meaning
// ACCEPT | input open, frames written into the ring at wr_frame/wr_idx
// CALC   | input stalled, one accumulator op issued per cycle, then drain
module delta_seq
    import mfcc_pkg::*;
#(
    parameter int NUM_COEF = mfcc_pkg::NUM_COEF,
    parameter int IDX_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic [15:0]        cep_in,
    input  logic               cep_valid,
    output logic               cep_ready,
    output logic [15:0]        regc_out,
    output logic               delta_new,
    output logic               delta_sub,
    output logic               delta_en,
    output logic               delta_shift,
    output logic               delta_vld,
    output logic [IDX_W-1:0]   delta_idx,
    output logic               busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEF - 1);
    localparam logic [FR_W-1:0]  FR_ONE   = FR_W'(1);
    localparam logic [FR_W-1:0]  FR_TWO   = FR_W'(2);
    localparam logic [FR_W-1:0]  FR_FOUR  = FR_W'(4);

    state_t             state_q, state_d;
    step_t              step_q, step_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic               drain_q, drain_d;
    logic [FR_W-1:0]    wr_frame_q, wr_frame_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [FR_W-1:0]    frames_q, frames_d;
    logic               wr_en;

    logic [CEP_W-1:0]   regc_q, regc_d;
    logic               new_q, new_d;
    logic               sub_q, sub_d;
    logic               en_q, en_d;
    logic               last_q, last_d;
    logic [IDX_W-1:0]   op_idx_q, op_idx_d;
    logic               vld_q, vld_d;
    logic [IDX_W-1:0]   didx_q, didx_d;

    logic               issue;
    logic [FR_W-1:0]    rd_frame;
    logic [CEP_W-1:0]   rd_data;

    cep_hist_buf #(
        .NUM_COEF (NUM_COEF),
        .IDX_W    (IDX_W)
    ) u_hist (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_frame (wr_frame_q),
        .wr_idx   (wr_idx_q),
        .wr_data  (cep_in),
        .rd_frame (rd_frame),
        .rd_idx   (k_q),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCEPT;
            step_q     <= S_NEW;
            k_q        <= '0;
            drain_q    <= 1'b0;
            wr_frame_q <= '0;
            wr_idx_q   <= '0;
            frames_q   <= '0;
            regc_q     <= '0;
            new_q      <= 1'b0;
            sub_q      <= 1'b0;
            en_q       <= 1'b0;
            last_q     <= 1'b0;
            op_idx_q   <= '0;
            vld_q      <= 1'b0;
            didx_q     <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            k_q        <= k_d;
            drain_q    <= drain_d;
            wr_frame_q <= wr_frame_d;
            wr_idx_q   <= wr_idx_d;
            frames_q   <= frames_d;
            regc_q     <= regc_d;
            new_q      <= new_d;
            sub_q      <= sub_d;
            en_q       <= en_d;
            last_q     <= last_d;
            op_idx_q   <= op_idx_d;
            vld_q      <= vld_d;
            didx_q     <= didx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        k_d        = k_q;
        drain_d    = drain_q;
        wr_frame_d = wr_frame_q;
        wr_idx_d   = wr_idx_q;
        frames_d   = frames_q;
        wr_en      = 1'b0;
        if (clr) begin
            state_d  = ACCEPT;
            step_d   = S_NEW;
            k_d      = '0;
            drain_d  = 1'b0;
            wr_idx_d = '0;
            frames_d = '0;
        end else begin
            case (state_q)
                ACCEPT: begin
                    if (cep_valid) begin
                        wr_en = 1'b1;
                        if (wr_idx_q == LAST_IDX) begin
                            wr_idx_d = '0;
                            if (frames_q < FR_W'(NFR - 1)) begin
                                frames_d   = frames_q + FR_ONE;
                                wr_frame_d = fr_add(wr_frame_q, FR_ONE);
                            end else begin
                                // Ring full: the frame just written becomes t+2.
                                frames_d = FR_W'(NFR);
                                state_d  = CALC;
                                step_d   = S_NEW;
                                k_d      = '0;
                                drain_d  = 1'b0;
                            end
                        end else begin
                            wr_idx_d = wr_idx_q + 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (drain_q) begin
                        // Oldest slot (t-2) is next in line to be overwritten.
                        state_d    = ACCEPT;
                        drain_d    = 1'b0;
                        wr_frame_d = fr_add(wr_frame_q, FR_ONE);
                    end else if (step_q == S_SUB1) begin
                        step_d = S_NEW;
                        if (k_q == LAST_IDX)
                            drain_d = 1'b1;
                        else
                            k_d = k_q + 1'b1;
                    end else begin
                        step_d = step_t'(step_q + 3'd1);
                    end
                end
                default: state_d = ACCEPT;
            endcase
        end
    end

    always_comb begin
        issue    = (state_q == CALC) && !drain_q && !clr;
        rd_frame = wr_frame_q;
        case (step_q)
            S_SUB2, S_SUB2B: rd_frame = fr_add(wr_frame_q, FR_ONE);
            S_ADD1:          rd_frame = fr_add(wr_frame_q, FR_FOUR);
            S_SUB1:          rd_frame = fr_add(wr_frame_q, FR_TWO);
            default:         rd_frame = wr_frame_q;
        endcase
        regc_d   = issue ? rd_data : regc_q;
        new_d    = issue && (step_q == S_NEW);
        sub_d    = issue && ((step_q == S_SUB2) || (step_q == S_SUB2B) || (step_q == S_SUB1));
        en_d     = issue && ((step_q == S_ADD2) || (step_q == S_ADD1));
        last_d   = issue && (step_q == S_SUB1);
        op_idx_d = issue ? k_q : op_idx_q;
        // Result is valid the cycle after the final subtract lands in the accumulator.
        vld_d    = !clr && last_q;
        didx_d   = vld_d ? op_idx_q : didx_q;
    end

    assign cep_ready   = (state_q == ACCEPT);
    assign busy        = (state_q == CALC);
    assign regc_out    = regc_q;
    assign delta_new   = new_q;
    assign delta_sub   = sub_q;
    assign delta_en    = en_q;
    assign delta_shift = 1'b0;
    assign delta_vld   = vld_q;
    assign delta_idx   = didx_q;

endmodule

// File: tb/tb_delta_seq.sv
// Directed bench for delta_seq with a behavioural delta accumulator downstream.
module tb_delta_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [15:0] cep_in;
    logic        cep_valid;
    logic        cep_ready;
    logic [15:0] regc_out;
    logic        delta_new, delta_sub, delta_en, delta_shift;
    logic        delta_vld;
    logic [3:0]  delta_idx;
    logic        busy;

    logic signed [17:0] acc;
    logic [15:0]        delta_out;

    int n_vec = 0;
    int n_err = 0;

    delta_seq #(.NUM_COEF(13), .IDX_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .cep_in      (cep_in),
        .cep_valid   (cep_valid),
        .cep_ready   (cep_ready),
        .regc_out    (regc_out),
        .delta_new   (delta_new),
        .delta_sub   (delta_sub),
        .delta_en    (delta_en),
        .delta_shift (delta_shift),
        .delta_vld   (delta_vld),
        .delta_idx   (delta_idx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (delta_new)
            acc <= {{2{regc_out[15]}}, regc_out};
        else if (delta_sub)
            acc <= acc - {{2{regc_out[15]}}, regc_out};
        else if (delta_en)
            acc <= acc + {{2{regc_out[15]}}, regc_out};
    end
    assign delta_out = acc[17:2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: frame f coef k = 100*f*(k+1); mode 1: -100*f; mode 2: 16'h7FFF
    task automatic send_frame(input int f, input int mode, input bit hold);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            case (mode)
                0:       cep_in = 16'(100 * f * (k + 1));
                1:       cep_in = 16'(-100 * f);
                default: cep_in = 16'h7FFF;
            endcase
            cep_valid = 1'b1;
        end
        @(negedge clk);
        if (hold)
            cep_in = 16'h1234;
        else
            cep_valid = 1'b0;
    endtask

    // Called at the negedge of the first CALC cycle.
    task automatic run_calc(input int mode, input string tag);
        int busy_cyc = 0;
        int nres = 0;
        int last = 0;
        logic [15:0] exp_out;
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        for (int cyc = 0; cyc < 200 && nres < 13; cyc++) begin
            if (cyc > 0)
                @(negedge clk);
            if (!cep_ready)
                busy_cyc++;
            if (delta_vld) begin
                case (mode)
                    0:       exp_out = 16'(250 * (nres + 1));
                    1:       exp_out = 16'hFF06;
                    default: exp_out = 16'h0000;
                endcase
                chk({tag, "_idx"}, 32'(delta_idx), 32'(nres));
                chk({tag, "_dout"}, 32'(delta_out), 32'(exp_out));
                if (nres > 0)
                    chk({tag, "_spacing"}, 32'(cyc - last), 32'd6);
                last = cyc;
                nres++;
            end
            if (cep_ready)
                cep_valid = 1'b0;
        end
        chk({tag, "_nres"}, 32'(nres), 32'd13);
        chk({tag, "_ready_low_cycles"}, 32'(busy_cyc), 32'd79);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic watch_idle(input int n, input string tag);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (busy || delta_vld || !cep_ready)
                bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_regc"},  32'(regc_out),  32'd0);
        chk({tag, "_new"},   32'(delta_new), 32'd0);
        chk({tag, "_sub"},   32'(delta_sub), 32'd0);
        chk({tag, "_en"},    32'(delta_en),  32'd0);
        chk({tag, "_shift"}, 32'(delta_shift), 32'd0);
        chk({tag, "_vld"},   32'(delta_vld), 32'd0);
        chk({tag, "_idx"},   32'(delta_idx), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_ready"}, 32'(cep_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        cep_in    = '0;
        cep_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Ramp, index-weighted so each coefficient has a distinct result
        for (int f = 0; f < 4; f++)
            send_frame(f, 0, 1'b0);
        chk("ramp_no_calc_early", 32'(busy), 32'd0);
        send_frame(4, 0, 1'b0);
        run_calc(0, "ramp");

        // Wrap through every ring rotation
        for (int f = 5; f < 10; f++) begin
            send_frame(f, 0, 1'b0);
            run_calc(0, "wrap");
        end

        // Negative ramp
        pulse_clr();
        for (int f = 0; f < 5; f++)
            send_frame(f, 1, 1'b0);
        run_calc(1, "negramp");

        // Constant frames, source keeps valid high with other data while stalled
        pulse_clr();
        for (int f = 0; f < 4; f++)
            send_frame(f, 2, 1'b0);
        send_frame(4, 2, 1'b1);
        run_calc(2, "const");
        chk("const_valid_dropped", 32'(cep_valid), 32'd0);

        // clr mid-CALC at k=5, step 3
        pulse_clr();
        for (int f = 0; f < 5; f++)
            send_frame(f, 0, 1'b0);
        repeat (34) @(negedge clk);
        chk("clr_at_k5s3_sub", 32'(delta_sub), 32'd1);
        chk("clr_at_k5s3_idx", 32'(delta_idx), 32'd4);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_new",   32'(delta_new), 32'd0);
        chk("clr_sub",   32'(delta_sub), 32'd0);
        chk("clr_en",    32'(delta_en),  32'd0);
        chk("clr_vld",   32'(delta_vld), 32'd0);
        chk("clr_ready", 32'(cep_ready), 32'd1);
        watch_idle(20, "clr_no_result");
        for (int f = 0; f < 4; f++)
            send_frame(f, 0, 1'b0);
        watch_idle(10, "clr_four_frames_idle");
        send_frame(4, 0, 1'b0);
        run_calc(0, "after_clr");

        // Asynchronous reset in the middle of CALC
        send_frame(5, 0, 1'b0);
        repeat (20) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 4; f++)
            send_frame(f, 0, 1'b0);
        watch_idle(10, "rst_four_frames_idle");
        send_frame(4, 0, 1'b0);
        run_calc(0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
